// File: rtl/scoreboard_pkg.sv
// Shared definitions for the multi-channel event scoreboard: FSM state encoding.
package scoreboard_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } sb_state_t;

endpackage

// File: rtl/scoreboard_chan.sv
// One event channel: counter with saturate-or-wrap behaviour and a sticky overflow flag.
module scoreboard_chan
    import scoreboard_pkg::*;
#(
    parameter int EVT_W    = 8,
    parameter int SATURATE = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_clear,
    input  logic             i_enable,
    input  logic             i_event,
    output logic [EVT_W-1:0] o_cnt,
    output logic             o_ovf
);

    logic [EVT_W-1:0] r_cnt;
    logic             r_ovf;
    logic             w_full;

    assign w_full = (r_cnt == {EVT_W{1'b1}});

    always_ff @(posedge clk) begin
        if (reset || i_clear) begin
            r_cnt <= '0;
            r_ovf <= 1'b0;
        end else if (i_enable && i_event) begin
            if (w_full) begin
                // Overflow is sticky until the next clear, whichever policy applies to the count.
                r_ovf <= 1'b1;
                r_cnt <= (SATURATE != 0) ? r_cnt : '0;
            end else begin
                r_cnt <= r_cnt + EVT_W'(1);
            end
        end
    end

    assign o_cnt = r_cnt;
    assign o_ovf = r_ovf;

endmodule

// File: rtl/scoreboard_mc.sv
// Multi-channel event scoreboard: counts per-channel events over a programmable cycle window.
module scoreboard_mc
    import scoreboard_pkg::*;
#(
    parameter int NCH      = 4,
    parameter int EVT_W    = 8,
    parameter int DATA_W   = 24,
    parameter int SATURATE = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NCH-1:0]       i_event,
    input  logic                 i_start,
    input  logic [DATA_W-1:0]    i_window,
    input  logic                 i_ack,
    output logic                 o_busy,
    output logic                 o_valid,
    output logic [NCH*EVT_W-1:0] o_event_ctr,
    output logic [NCH-1:0]       o_ovf,
    output logic [DATA_W-1:0]    o_data_ctr
);

    sb_state_t         r_state;
    sb_state_t         w_state_nxt;
    logic [DATA_W-1:0] r_window;
    logic [DATA_W-1:0] r_data_ctr;
    logic              r_busy;
    logic              r_valid;
    logic              w_clear;
    logic              w_enable;
    logic              w_last;

    assign w_last = (r_data_ctr == r_window - DATA_W'(1));

    always_comb begin
        w_state_nxt = r_state;
        w_clear     = 1'b0;
        w_enable    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_start) begin
                    w_clear     = 1'b1;
                    w_state_nxt = (i_window == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                w_enable = 1'b1;
                if (w_last) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                if (i_ack) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_valid <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_busy  <= (w_state_nxt == ST_RUN);
            r_valid <= (w_state_nxt == ST_DONE);
        end
    end

    // Window length is only meaningful once a start is accepted, so it needs no reset.
    always_ff @(posedge clk) begin
        if (w_clear) begin
            r_window <= i_window;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || w_clear) begin
            r_data_ctr <= '0;
        end else if (w_enable) begin
            r_data_ctr <= r_data_ctr + DATA_W'(1);
        end
    end

    for (genvar n = 0; n < NCH; n++) begin : g_chan
        scoreboard_chan #(
            .EVT_W    (EVT_W),
            .SATURATE (SATURATE)
        ) u_chan (
            .clk      (clk),
            .reset    (reset),
            .i_clear  (w_clear),
            .i_enable (w_enable),
            .i_event  (i_event[n]),
            .o_cnt    (o_event_ctr[n*EVT_W +: EVT_W]),
            .o_ovf    (o_ovf[n])
        );
    end

    assign o_busy     = r_busy;
    assign o_valid    = r_valid;
    assign o_data_ctr = r_data_ctr;

endmodule

// File: tb/tb_scoreboard_mc.sv
// Directed bench for scoreboard_mc: default instance plus two 4-bit saturate/wrap instances.
module tb_scoreboard_mc;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  i_event;
    logic        i_start;
    logic [23:0] i_window;
    logic        i_ack;

    logic        busy, valid, busy_s, valid_s, busy_w, valid_w;
    logic [31:0] ev;
    logic [15:0] ev_s, ev_w;
    logic [3:0]  ovf, ovf_s, ovf_w;
    logic [23:0] dctr, dctr_s, dctr_w;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    scoreboard_mc dut (
        .clk(clk), .reset(reset), .i_event(i_event), .i_start(i_start),
        .i_window(i_window), .i_ack(i_ack), .o_busy(busy), .o_valid(valid),
        .o_event_ctr(ev), .o_ovf(ovf), .o_data_ctr(dctr)
    );

    scoreboard_mc #(.EVT_W(4), .SATURATE(1)) dut_sat (
        .clk(clk), .reset(reset), .i_event(i_event), .i_start(i_start),
        .i_window(i_window), .i_ack(i_ack), .o_busy(busy_s), .o_valid(valid_s),
        .o_event_ctr(ev_s), .o_ovf(ovf_s), .o_data_ctr(dctr_s)
    );

    scoreboard_mc #(.EVT_W(4), .SATURATE(0)) dut_wrap (
        .clk(clk), .reset(reset), .i_event(i_event), .i_start(i_start),
        .i_window(i_window), .i_ack(i_ack), .o_busy(busy_w), .o_valid(valid_w),
        .o_event_ctr(ev_w), .o_ovf(ovf_w), .o_data_ctr(dctr_w)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_default(input string tag, input logic b, input logic v,
                                 input logic [31:0] e, input logic [3:0] o, input logic [23:0] d);
        chk({tag, "_busy"}, 32'(busy), 32'(b));
        chk({tag, "_valid"}, 32'(valid), 32'(v));
        chk({tag, "_ev"}, ev, e);
        chk({tag, "_ovf"}, 32'(ovf), 32'(o));
        chk({tag, "_dctr"}, 32'(dctr), 32'(d));
    endtask

    initial begin
        reset = 1'b1; i_event = '0; i_start = 1'b0; i_window = '0; i_ack = 1'b0;
        step(3);
        reset = 1'b0;
        step(1);
        check_default("rst", 1'b0, 1'b0, 32'h0, 4'h0, 24'd0);

        // Basic window of 10 with ch0 firing every cycle; start pulsed mid-run is ignored.
        i_start = 1'b1; i_window = 24'd10; i_event = 4'b0001;
        step(1);
        i_start = 1'b0;
        chk("acc_busy", 32'(busy), 32'd1);
        chk("acc_ev", ev, 32'h0);
        step(4);
        i_start = 1'b1; i_window = 24'd3;
        step(1);
        i_start = 1'b0;
        step(4);
        chk("run9_busy", 32'(busy), 32'd1);
        chk("run9_dctr", 32'(dctr), 32'd9);
        step(1);
        check_default("basic", 1'b0, 1'b1, 32'h0000_000A, 4'h0, 24'd10);

        // Hold in DONE without ack, with events and a start pulse: nothing moves.
        i_event = 4'b1111;
        step(2);
        i_start = 1'b1;
        step(1);
        i_start = 1'b0;
        step(2);
        check_default("hold", 1'b0, 1'b1, 32'h0000_000A, 4'h0, 24'd10);

        // Ack together with start: ack wins, no new window.
        i_ack = 1'b1; i_start = 1'b1; i_window = 24'd5;
        step(1);
        i_ack = 1'b0; i_start = 1'b0;
        check_default("ackst", 1'b0, 1'b0, 32'h0000_000A, 4'h0, 24'd10);
        step(2);
        chk("ackst_idle_busy", 32'(busy), 32'd0);
        chk("ackst_idle_valid", 32'(valid), 32'd0);

        // Window of 20 on ch0: 4-bit saturate holds 15, wrap gives 20 mod 16 = 4.
        i_start = 1'b1; i_window = 24'd20; i_event = 4'b0001;
        step(1);
        i_start = 1'b0;
        step(20);
        check_default("w20", 1'b0, 1'b1, 32'h0000_0014, 4'h0, 24'd20);
        chk("sat_ch0", 32'(ev_s[3:0]), 32'd15);
        chk("sat_ovf", 32'(ovf_s), 32'h1);
        chk("sat_valid", 32'(valid_s), 32'd1);
        chk("wrap_ch0", 32'(ev_w[3:0]), 32'd4);
        chk("wrap_ovf", 32'(ovf_w), 32'h1);
        chk("wrap_ch1", 32'(ev_w[7:4]), 32'd0);
        i_ack = 1'b1;
        step(1);
        i_ack = 1'b0;

        // Zero-length window goes straight to DONE with everything cleared.
        i_start = 1'b1; i_window = 24'd0; i_event = 4'b1111;
        step(1);
        i_start = 1'b0;
        check_default("zero", 1'b0, 1'b1, 32'h0, 4'h0, 24'd0);
        chk("zero_sat_ovf", 32'(ovf_s), 32'h0);
        i_ack = 1'b1;
        step(1);
        i_ack = 1'b0;

        // Reset in the middle of a 100-cycle window, asserted with start/ack/events.
        i_start = 1'b1; i_window = 24'd100; i_event = 4'b0011;
        step(1);
        i_start = 1'b0;
        step(50);
        check_default("mid", 1'b1, 1'b0, 32'h0000_3232, 4'h0, 24'd50);
        reset = 1'b1; i_start = 1'b1; i_ack = 1'b1;
        step(1);
        reset = 1'b0; i_start = 1'b0; i_ack = 1'b0;
        check_default("midrst", 1'b0, 1'b0, 32'h0, 4'h0, 24'd0);
        step(2);
        chk("midrst_idle", 32'(busy), 32'd0);

        // Fresh window after reset.
        i_start = 1'b1; i_window = 24'd3; i_event = 4'b0101;
        step(1);
        i_start = 1'b0;
        step(3);
        check_default("fresh", 1'b0, 1'b1, 32'h0003_0003, 4'h0, 24'd3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/scoreboard_mc.md
SCOREBOARD_MC -- requirements
Module: scoreboard_mc

Interface
REQ-001 SHALL have parameter NCH, default 4, number of independent event channels (1..16).
REQ-002 SHALL have parameter EVT_W, default 8, per-channel event counter width (2..32).
REQ-003 SHALL have parameter DATA_W, default 24, window/cycle counter width (2..32).
REQ-004 SHALL have parameter SATURATE, default 1: 1 = event counters hold at max; 0 = wrap.
REQ-005 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-006 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-007 SHALL have port i_event  input  NCH  per-channel event strobe, one count per asserted cycle.
REQ-008 SHALL have port i_start  input  1  start a measurement window.
REQ-009 SHALL have port i_window  input  DATA_W  window length in cycles, sampled when start is accepted.
REQ-010 SHALL have port i_ack  input  1  consumer acknowledges results.
REQ-011 SHALL have port o_busy  output  1  high in RUN.
REQ-012 SHALL have port o_valid  output  1  high in DONE; results stable.
REQ-013 SHALL have port o_event_ctr  output  NCH*EVT_W  channel n at bits [n*EVT_W +: EVT_W].
REQ-014 SHALL have port o_ovf  output  NCH  per-channel sticky overflow flag.
REQ-015 SHALL have port o_data_ctr  output  DATA_W  cycles elapsed in current/last window.

Function
REQ-016 SHALL implement FSM states IDLE, RUN, DONE; only state changes on clk edge.
REQ-017 IDLE: i_start high SHALL clear all counters and o_ovf, latch i_window, go to RUN next cycle; i_event in the accepting cycle SHALL NOT be counted.
REQ-018 IDLE with i_start high and i_window = 0 SHALL go directly to DONE with all counters zero.
REQ-019 RUN: each cycle SHALL increment o_data_ctr by 1 and each channel with i_event[n] high by 1.
REQ-020 RUN SHALL last exactly window cycles; in the cycle o_data_ctr == window-1 the final count update occurs and state goes to DONE.
REQ-021 Channel at all-ones receiving an event: SATURATE=1 SHALL hold value; SATURATE=0 SHALL wrap to 0; both SHALL set o_ovf[n].
REQ-022 o_data_ctr SHALL never overflow, as it stops at window <= 2^DATA_W-1.
REQ-023 DONE: counters and o_ovf SHALL be frozen; o_valid held until i_ack high, then IDLE next cycle.
REQ-024 i_start SHALL be ignored in RUN and DONE; i_ack SHALL be ignored in IDLE and RUN.
REQ-025 Simultaneous i_ack and i_start in DONE: ack SHALL be honoured, start dropped.
REQ-026 Outputs SHALL be registered; no combinational path from inputs to outputs.

Reset
REQ-027 reset high at clk edge SHALL force IDLE, o_event_ctr = 0, o_data_ctr = 0, o_ovf = 0, o_busy = 0, o_valid = 0, in any state, mid-window included.
REQ-028 reset SHALL take priority over i_start, i_ack and i_event in the same cycle.

Structure
REQ-029 FSM state encoding (IDLE=0, RUN=1, DONE=2, 2-bit) SHALL live in shared package scoreboard_pkg.
REQ-030 Per-channel counter-plus-overflow logic SHALL be sub-module scoreboard_chan (params EVT_W, SATURATE; inputs clear, enable, event), instantiated NCH times via generate.

Verification
REQ-031 Basic: NCH=4, start with window=10, i_event=4'b0001 every cycle -> after 10 RUN cycles o_valid=1, ch0=10, ch1..3=0, o_data_ctr=10.
REQ-032 Saturate: EVT_W=4, SATURATE=1, window=20, ch0 event every cycle -> ch0=15, o_ovf[0]=1; SATURATE=0 -> ch0=4, o_ovf[0]=1.
REQ-033 Zero window: start with i_window=0 and events high -> o_valid next cycle, all counts 0, o_data_ctr=0.
REQ-034 Handshake: hold i_ack low 5 cycles in DONE -> outputs unchanged; pulse i_start in RUN and DONE -> no effect; i_ack with i_start -> IDLE, no new window.
REQ-035 Reset mid-window: window=100, reset at cycle 50 -> next cycle all outputs 0, state IDLE; new start gives correct fresh counts.
